axis_write_data_mc: RTL and testbench

- Multi-channel successor of the single-stream AXI write-data engine.
- Accepts per-channel DATA_WIDTH streams into per-channel buffers. Serves write commands in the order the address-channel block issued them.
- Packs words into AXI_DATA_WIDTH beats and drives the AXI W channel, including WSTRB for a partial final beat and WLAST on burst or stream boundaries.

---
 rtl/axis_write_data_mc.sv | 272 +++++++++++++++++++++++++++
 tb/tb_axis_write_data_mc.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_write_data_mc.sv
// Multi-channel AXI write-data engine: per-channel word FIFOs, a shared command FIFO,
// and a word-to-beat packer with a one-entry skid in front of the W-channel register.
module axis_write_data_mc #(
  parameter int NUM_CH         = 2,
  parameter int CH_WIDTH       = 1,
  parameter int BUF_CFG_AWIDTH = 5,
  parameter int BUF_AWIDTH     = 9,
  parameter int CFG_DWIDTH     = 32,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CH_WIDTH-1:0]          cfg_chan,
  input  logic [CFG_DWIDTH-1:0]        cfg_length,
  input  logic                         cfg_val,
  output logic                         cfg_rdy,
  output logic [AXI_DATA_WIDTH-1:0]    axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]  axi_wstrb,
  output logic                         axi_wlast,
  output logic                         axi_wvalid,
  input  logic                         axi_wready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data,
  input  logic [NUM_CH-1:0]            valid,
  output logic [NUM_CH-1:0]            ready,
  output logic [NUM_CH-1:0]            chan_done,
  output logic                         cfg_err
);

  localparam int RATIO     = AXI_DATA_WIDTH / DATA_WIDTH;
  localparam int LANE_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int STRB_W    = AXI_DATA_WIDTH / 8;
  localparam int LSTRB_W   = DATA_WIDTH / 8;
  localparam int CMD_DEPTH = 1 << BUF_CFG_AWIDTH;
  localparam int BUF_DEPTH = 1 << BUF_AWIDTH;
  localparam int CMD_W     = CH_WIDTH + CFG_DWIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_LOAD   = 3'b010,
    S_ACTIVE = 3'b100
  } state_t;

  state_t r_state, w_state_nxt;

  // ---------------- command FIFO ----------------
  logic [CMD_W-1:0]          r_cmd_mem [CMD_DEPTH];
  logic [BUF_CFG_AWIDTH-1:0] r_cmd_wp, r_cmd_rp;
  logic [BUF_CFG_AWIDTH:0]   r_cmd_cnt;
  logic                      w_cmd_full, w_cmd_empty, w_cmd_push, w_cmd_pop;

  assign w_cmd_full  = (r_cmd_cnt == (BUF_CFG_AWIDTH+1)'(CMD_DEPTH));
  assign w_cmd_empty = (r_cmd_cnt == '0);
  assign w_cmd_push  = cfg_val & ~w_cmd_full;
  assign w_cmd_pop   = (r_state == S_IDLE) & ~w_cmd_empty;
  assign cfg_rdy     = ~w_cmd_full;

  always_ff @(posedge clk) begin
    if (w_cmd_push) r_cmd_mem[r_cmd_wp] <= {cfg_chan, cfg_length};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd_wp  <= '0;
      r_cmd_rp  <= '0;
      r_cmd_cnt <= '0;
    end else begin
      if (w_cmd_push) r_cmd_wp <= r_cmd_wp + BUF_CFG_AWIDTH'(1);
      if (w_cmd_pop)  r_cmd_rp <= r_cmd_rp + BUF_CFG_AWIDTH'(1);
      case ({w_cmd_push, w_cmd_pop})
        2'b10:   r_cmd_cnt <= r_cmd_cnt + (BUF_CFG_AWIDTH+1)'(1);
        2'b01:   r_cmd_cnt <= r_cmd_cnt - (BUF_CFG_AWIDTH+1)'(1);
        default: r_cmd_cnt <= r_cmd_cnt;
      endcase
    end
  end

  // ---------------- per-channel data FIFOs ----------------
  logic [DATA_WIDTH-1:0] w_fifo_dout [NUM_CH];
  logic [NUM_CH-1:0]     w_fifo_nempty;
  logic [NUM_CH-1:0]     w_pop;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [BUF_AWIDTH-1:0] r_wp, r_rp;
    logic [BUF_AWIDTH:0]   r_cnt;
    logic                  r_rdy;
    logic                  w_push;

    assign w_push           = valid[g] & (r_cnt != (BUF_AWIDTH+1)'(BUF_DEPTH));
    assign w_fifo_dout[g]   = r_mem[r_rp];
    assign w_fifo_nempty[g] = (r_cnt != '0);
    assign ready[g]         = r_rdy;

    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
        r_rdy <= 1'b0;
      end else begin
        if (w_push)   r_wp <= r_wp + BUF_AWIDTH'(1);
        if (w_pop[g]) r_rp <= r_rp + BUF_AWIDTH'(1);
        case ({w_push, w_pop[g]})
          2'b10:   r_cnt <= r_cnt + (BUF_AWIDTH+1)'(1);
          2'b01:   r_cnt <= r_cnt - (BUF_AWIDTH+1)'(1);
          default: r_cnt <= r_cnt;
        endcase
        r_rdy <= (r_cnt < (BUF_AWIDTH+1)'(BUF_DEPTH/2));
      end
    end
  end

  // ---------------- stream control and packer ----------------
  logic [CH_WIDTH-1:0]       r_chan;
  logic [CFG_DWIDTH-1:0]     r_len, r_word_cnt;
  logic [AXI_LEN_WIDTH-1:0]  r_beat_cnt;
  logic [LANE_W-1:0]         r_lane;
  logic [AXI_DATA_WIDTH-1:0] r_asm_data, r_out_data, r_sk_data;
  logic [STRB_W-1:0]         r_asm_strb, r_out_strb, r_sk_strb;
  logic                      r_out_valid, r_out_last, r_out_eos;
  logic                      r_sk_valid, r_sk_last, r_sk_eos;
  logic [NUM_CH-1:0]         r_chan_done;
  logic                      r_cfg_err;

  logic                      w_chan_ok, w_more, w_last_word, w_out_free;
  logic                      w_sel_nempty, w_word_pop, w_beat_done, w_beat_last, w_eos_hs;
  logic [DATA_WIDTH-1:0]     w_sel_word;
  logic [AXI_DATA_WIDTH-1:0] w_beat_data;
  logic [STRB_W-1:0]         w_beat_strb;
  logic [NUM_CH-1:0]         w_done_set;

  assign w_chan_ok   = ({1'b0, r_chan} < (CH_WIDTH+1)'(NUM_CH));
  // Popping stops at word_cnt == len, so len = all-ones never wraps the counter.
  assign w_more      = (r_word_cnt != r_len);
  assign w_last_word = (r_word_cnt == r_len - CFG_DWIDTH'(1));
  assign w_out_free  = ~r_out_valid | axi_wready;
  assign w_word_pop  = (r_state == S_ACTIVE) & w_more & w_sel_nempty & ~r_sk_valid;
  assign w_beat_done = w_word_pop & ((r_lane == LANE_W'(RATIO-1)) | w_last_word);
  assign w_beat_last = (r_beat_cnt == '1) | w_last_word;
  assign w_eos_hs    = r_out_valid & axi_wready & r_out_eos;

  always_comb begin
    w_sel_word   = '0;
    w_sel_nempty = 1'b0;
    w_pop        = '0;
    w_done_set   = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (r_chan == CH_WIDTH'(c)) begin
        w_sel_word    = w_fifo_dout[c];
        w_sel_nempty  = w_fifo_nempty[c];
        w_pop[c]      = w_word_pop;
        w_done_set[c] = ((r_state == S_LOAD) & (r_len == '0)) |
                        ((r_state == S_ACTIVE) & w_eos_hs);
      end
    end
  end

  always_comb begin
    w_beat_data = r_asm_data;
    w_beat_strb = r_asm_strb;
    for (int unsigned l = 0; l < RATIO; l++) begin
      if (r_lane == LANE_W'(l)) begin
        w_beat_data[l*DATA_WIDTH +: DATA_WIDTH] = w_sel_word;
        w_beat_strb[l*LSTRB_W +: LSTRB_W]       = '1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!w_cmd_empty) w_state_nxt = S_LOAD;
      S_LOAD:   w_state_nxt = ((r_len == '0) || !w_chan_ok) ? S_IDLE : S_ACTIVE;
      S_ACTIVE: if (w_eos_hs) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_chan      <= '0;
      r_len       <= '0;
      r_word_cnt  <= '0;
      r_beat_cnt  <= '0;
      r_lane      <= '0;
      r_asm_data  <= '0;
      r_asm_strb  <= '0;
      r_chan_done <= '0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_chan_done <= w_done_set;
      if (w_cmd_pop) {r_chan, r_len} <= r_cmd_mem[r_cmd_rp];
      if (r_state == S_LOAD) begin
        r_word_cnt <= '0;
        r_beat_cnt <= '0;
        r_lane     <= '0;
        r_asm_data <= '0;
        r_asm_strb <= '0;
        if (!w_chan_ok) r_cfg_err <= 1'b1;
      end else if (w_word_pop) begin
        r_word_cnt <= r_word_cnt + CFG_DWIDTH'(1);
        if (w_beat_done) begin
          r_beat_cnt <= r_beat_cnt + AXI_LEN_WIDTH'(1);
          r_lane     <= '0;
          r_asm_data <= '0;
          r_asm_strb <= '0;
        end else begin
          r_lane     <= r_lane + LANE_W'(1);
          r_asm_data <= w_beat_data;
          r_asm_strb <= w_beat_strb;
        end
      end
    end
  end

  // New beats are only formed while the skid is empty, so the skid always drains first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_strb  <= '0;
      r_out_last  <= 1'b0;
      r_out_eos   <= 1'b0;
      r_sk_valid  <= 1'b0;
      r_sk_data   <= '0;
      r_sk_strb   <= '0;
      r_sk_last   <= 1'b0;
      r_sk_eos    <= 1'b0;
    end else if (r_sk_valid) begin
      if (w_out_free) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_sk_data;
        r_out_strb  <= r_sk_strb;
        r_out_last  <= r_sk_last;
        r_out_eos   <= r_sk_eos;
        r_sk_valid  <= 1'b0;
      end
    end else if (w_beat_done) begin
      if (w_out_free) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_beat_data;
        r_out_strb  <= w_beat_strb;
        r_out_last  <= w_beat_last;
        r_out_eos   <= w_last_word;
      end else begin
        r_sk_valid  <= 1'b1;
        r_sk_data   <= w_beat_data;
        r_sk_strb   <= w_beat_strb;
        r_sk_last   <= w_beat_last;
        r_sk_eos    <= w_last_word;
      end
    end else if (axi_wready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign axi_wvalid = r_out_valid;
  assign axi_wdata  = r_out_data;
  assign axi_wstrb  = r_out_strb;
  assign axi_wlast  = r_out_last;
  assign chan_done  = r_chan_done;
  assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_axis_write_data_mc.sv
// Directed bench: two-channel 64/32 packer (A) and single-channel 32/32 engine (B), both with 4-beat bursts.
module tb_axis_write_data_mc;

  logic clk, rst;

  logic [1:0]  a_cfg_chan;
  logic [31:0] a_cfg_length;
  logic        a_cfg_val, a_cfg_rdy;
  logic [63:0] a_wdata;
  logic [7:0]  a_wstrb;
  logic        a_wlast, a_wvalid, a_wready;
  logic [63:0] a_data;
  logic [1:0]  a_valid, a_ready, a_chan_done;
  logic        a_cfg_err;

  logic [0:0]  b_cfg_chan;
  logic [31:0] b_cfg_length;
  logic        b_cfg_val, b_cfg_rdy;
  logic [31:0] b_wdata;
  logic [3:0]  b_wstrb;
  logic        b_wlast, b_wvalid, b_wready;
  logic [31:0] b_data;
  logic [0:0]  b_valid, b_ready, b_chan_done;
  logic        b_cfg_err;

  axis_write_data_mc #(
    .NUM_CH(2), .CH_WIDTH(2), .BUF_CFG_AWIDTH(3), .BUF_AWIDTH(7), .CFG_DWIDTH(32),
    .AXI_LEN_WIDTH(2), .AXI_DATA_WIDTH(64), .DATA_WIDTH(32)
  ) u_dut (
    .clk(clk), .rst(rst), .cfg_chan(a_cfg_chan), .cfg_length(a_cfg_length),
    .cfg_val(a_cfg_val), .cfg_rdy(a_cfg_rdy), .axi_wdata(a_wdata), .axi_wstrb(a_wstrb),
    .axi_wlast(a_wlast), .axi_wvalid(a_wvalid), .axi_wready(a_wready), .data(a_data),
    .valid(a_valid), .ready(a_ready), .chan_done(a_chan_done), .cfg_err(a_cfg_err)
  );

  axis_write_data_mc #(
    .NUM_CH(1), .CH_WIDTH(1), .BUF_CFG_AWIDTH(2), .BUF_AWIDTH(4), .CFG_DWIDTH(32),
    .AXI_LEN_WIDTH(2), .AXI_DATA_WIDTH(32), .DATA_WIDTH(32)
  ) u_dut1 (
    .clk(clk), .rst(rst), .cfg_chan(b_cfg_chan), .cfg_length(b_cfg_length),
    .cfg_val(b_cfg_val), .cfg_rdy(b_cfg_rdy), .axi_wdata(b_wdata), .axi_wstrb(b_wstrb),
    .axi_wlast(b_wlast), .axi_wvalid(b_wvalid), .axi_wready(b_wready), .data(b_data),
    .valid(b_valid), .ready(b_ready), .chan_done(b_chan_done), .cfg_err(b_cfg_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // wready mode: 0 = always ready, 1 = random 50%, 2 = held low
  int wr_mode = 0;
  initial begin
    a_wready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (wr_mode)
        1:       a_wready = 1'($urandom_range(0, 1));
        2:       a_wready = 1'b0;
        default: a_wready = 1'b1;
      endcase
    end
  end

  logic [72:0] qa[$];
  logic [36:0] qb[$];
  int          done_a [2];
  int          done_b;
  logic        hold_pend;
  logic [73:0] hold_val;

  initial begin
    done_a[0] = 0; done_a[1] = 0; done_b = 0; hold_pend = 1'b0; hold_val = '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (a_wvalid && a_wready) qa.push_back({a_wdata, a_wstrb, a_wlast});
      if (b_wvalid && b_wready) qb.push_back({b_wdata, b_wstrb, b_wlast});
      for (int i = 0; i < 2; i++) if (a_chan_done[i]) done_a[i]++;
      if (b_chan_done[0]) done_b++;
      if (hold_pend) check_eq("stall_hold", {a_wvalid, a_wdata, a_wstrb, a_wlast}, hold_val);
      hold_pend = a_wvalid && !a_wready;
      hold_val  = {a_wvalid, a_wdata, a_wstrb, a_wlast};
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic a_cmd(input logic [1:0] ch, input logic [31:0] len);
    a_cfg_chan = ch; a_cfg_length = len; a_cfg_val = 1'b1;
    @(posedge clk); #1;
    a_cfg_val = 1'b0;
  endtask

  task automatic a_word(input int ch, input logic [31:0] w);
    a_data[ch*32 +: 32] = w;
    a_valid = 2'b01 << ch;
    @(posedge clk); #1;
    a_valid = 2'b00;
  endtask

  task automatic wait_a(input string tag, input int n, input int budget);
    for (int k = 0; k < budget && qa.size() < n; k++) begin
      @(posedge clk); #1;
    end
    check_eq(tag, 80'(qa.size()), 80'(n));
  endtask

  function automatic logic [72:0] beat(input logic [31:0] hi, input logic [31:0] lo,
                                       input logic [7:0] strb, input logic last);
    return {hi, lo, strb, last};
  endfunction

  function automatic logic [72:0] pop_a();
    if (qa.size() == 0) return '1;
    return qa.pop_front();
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int d0, d1;
  logic [72:0] exp3 [5];

  initial begin
    rst = 1'b1;
    a_cfg_chan = '0; a_cfg_length = '0; a_cfg_val = 1'b0; a_data = '0; a_valid = '0;
    b_cfg_chan = '0; b_cfg_length = '0; b_cfg_val = 1'b0; b_data = '0; b_valid = '0;
    b_wready = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_wvalid", 80'(a_wvalid), 80'(0));
    check_eq("rst_wdata",  80'({a_wdata, a_wstrb, a_wlast}), 80'(0));
    check_eq("rst_ready",  80'(a_ready), 80'(0));
    check_eq("rst_done",   80'(a_chan_done), 80'(0));
    check_eq("rst_cfgerr", 80'(a_cfg_err), 80'(0));
    check_eq("rst_cfgrdy", 80'(a_cfg_rdy), 80'(1));
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    check_eq("ready_up", 80'(a_ready), 80'(3));

    // ch1, len 5: partial final beat
    d0 = done_a[0]; d1 = done_a[1];
    a_cmd(2'd1, 32'd5);
    for (int i = 1; i <= 5; i++) a_word(1, 32'(i));
    wait_a("t1_nbeats", 3, 100);
    check_eq("t1_b0", 80'(pop_a()), 80'(beat(32'd2, 32'd1, 8'hFF, 1'b0)));
    check_eq("t1_b1", 80'(pop_a()), 80'(beat(32'd4, 32'd3, 8'hFF, 1'b0)));
    check_eq("t1_b2", 80'(pop_a()), 80'(beat(32'd0, 32'd5, 8'h0F, 1'b1)));
    repeat (3) @(posedge clk); #1;
    check_eq("t1_done1", 80'(done_a[1] - d1), 80'(1));
    check_eq("t1_done0", 80'(done_a[0] - d0), 80'(0));

    // engine B: RATIO 1, 4-beat bursts, len 10
    b_cfg_chan = 1'b0; b_cfg_length = 32'd10; b_cfg_val = 1'b1;
    @(posedge clk); #1;
    b_cfg_val = 1'b0;
    for (int i = 0; i < 10; i++) begin
      b_data = 32'h100 + 32'(i); b_valid = 1'b1;
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    for (int k = 0; k < 100 && qb.size() < 10; k++) begin
      @(posedge clk); #1;
    end
    check_eq("t2_nbeats", 80'(qb.size()), 80'(10));
    for (int i = 0; i < 10 && qb.size() > 0; i++)
      check_eq($sformatf("t2_b%0d", i), 80'(qb.pop_front()),
               80'({32'h100 + 32'(i), 4'hF, (i == 3 || i == 7 || i == 9)}));
    repeat (3) @(posedge clk); #1;
    check_eq("t2_done", 80'(done_b), 80'(1));

    // command ordering with both FIFOs pre-filled
    for (int i = 0; i < 4; i++) a_word(0, 32'hA0 + 32'(i));
    for (int i = 0; i < 6; i++) a_word(1, 32'hB0 + 32'(i));
    a_cmd(2'd1, 32'd4);
    a_cmd(2'd0, 32'd4);
    a_cmd(2'd1, 32'd2);
    exp3[0] = beat(32'hB1, 32'hB0, 8'hFF, 1'b0);
    exp3[1] = beat(32'hB3, 32'hB2, 8'hFF, 1'b1);
    exp3[2] = beat(32'hA1, 32'hA0, 8'hFF, 1'b0);
    exp3[3] = beat(32'hA3, 32'hA2, 8'hFF, 1'b1);
    exp3[4] = beat(32'hB5, 32'hB4, 8'hFF, 1'b1);
    wait_a("t3_nbeats", 5, 100);
    for (int i = 0; i < 5; i++) check_eq($sformatf("t3_b%0d", i), 80'(pop_a()), 80'(exp3[i]));

    // len 64 under random wready stalls
    d0 = done_a[0];
    for (int i = 0; i < 64; i++) a_word(0, 32'h1000 + 32'(i));
    wr_mode = 1;
    a_cmd(2'd0, 32'd64);
    wait_a("t4_nbeats", 32, 2000);
    wr_mode = 0;
    for (int k = 0; k < 32; k++)
      check_eq($sformatf("t4_b%0d", k), 80'(pop_a()),
               80'(beat(32'h1000 + 32'(2*k+1), 32'h1000 + 32'(2*k), 8'hFF, (k % 4) == 3)));
    repeat (4) @(posedge clk); #1;
    check_eq("t4_done0", 80'(done_a[0] - d0), 80'(1));
    check_eq("t4_extra", 80'(qa.size()), 80'(0));

    // zero length and invalid channel
    d0 = done_a[0]; d1 = done_a[1];
    a_cmd(2'd0, 32'd0);
    a_cmd(2'd3, 32'd4);
    repeat (8) @(posedge clk); #1;
    check_eq("t5_nobeats", 80'(qa.size()), 80'(0));
    check_eq("t5_done0",   80'(done_a[0] - d0), 80'(1));
    check_eq("t5_done1",   80'(done_a[1] - d1), 80'(0));
    check_eq("t5_cfgerr",  80'(a_cfg_err), 80'(1));
    a_word(1, 32'hC0);
    a_word(1, 32'hC1);
    a_cmd(2'd1, 32'd2);
    wait_a("t5_nbeats", 1, 100);
    check_eq("t5_b0", 80'(pop_a()), 80'(beat(32'hC1, 32'hC0, 8'hFF, 1'b1)));
    repeat (3) @(posedge clk); #1;
    check_eq("t5_done1b",   80'(done_a[1] - d1), 80'(1));
    check_eq("t5_cfgstick", 80'(a_cfg_err), 80'(1));

    // reset mid-burst
    wr_mode = 2;
    for (int i = 0; i < 8; i++) a_word(0, 32'hE0 + 32'(i));
    a_cmd(2'd0, 32'd8);
    for (int k = 0; k < 50 && !a_wvalid; k++) begin
      @(posedge clk); #1;
    end
    check_eq("t6_wvalid_up", 80'(a_wvalid), 80'(1));
    rst = 1'b0;
    #1;
    check_eq("t6_wvalid_rst", 80'(a_wvalid), 80'(0));
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    wr_mode = 0;
    qa.delete();
    d0 = done_a[0];
    repeat (2) @(posedge clk); #1;
    check_eq("t6_ready", 80'(a_ready), 80'(3));
    check_eq("t6_cfgerr_clr", 80'(a_cfg_err), 80'(0));
    for (int i = 0; i < 3; i++) a_word(0, 32'hD0 + 32'(i));
    a_cmd(2'd0, 32'd3);
    wait_a("t6_nbeats", 2, 100);
    check_eq("t6_b0", 80'(pop_a()), 80'(beat(32'hD1, 32'hD0, 8'hFF, 1'b0)));
    check_eq("t6_b1", 80'(pop_a()), 80'(beat(32'h0,  32'hD2, 8'h0F, 1'b1)));
    repeat (3) @(posedge clk); #1;
    check_eq("t6_done0", 80'(done_a[0] - d0), 80'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
